// File: rtl/approx_ha_array_mul_pipe.sv
// Pipelined unsigned WxW approximate multiplier built from W/2 half-adder compressed
// partial-product arrays, with a per-transaction column mode and an exact reference product.
module approx_ha_array_mul_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_x,
  input  logic [W-1:0]               in_y,
  input  logic [(W/2)*(W-1)*2-1:0]   in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*W-1:0]             out_prod,
  output logic [2*W-1:0]             out_exact,
  output logic                       out_mismatch,
  output logic [CNT_W-1:0]           err_cnt,
  input  logic                       stats_clr
);

  localparam int NA = W / 2;
  localparam int NC = W - 1;
  localparam int MW = NA * NC * 2;
  localparam int PW = 2 * W;

  // Compressor cell, returns {carry, sum}.
  function automatic logic [1:0] ha_cell(input logic [1:0] mode, input logic a, input logic b);
    logic [1:0] cs;
    case (mode)
      2'b00:   cs = {a & b, a ^ b};
      2'b01:   cs = {1'b0, a | b};
      2'b10:   cs = {a, 1'b0};
      2'b11:   cs = 2'b00;
      default: cs = 2'b00;
    endcase
    return cs;
  endfunction

  logic                    adv_s;
  logic                    s1_valid_r;
  logic [W-1:0]            x_r;
  logic [W-1:0]            y_r;
  logic [MW-1:0]           mode_r;
  logic [NA-1:0][W:0]      t_s;
  logic [NA-1:0][W-2:0]    b_s;
  logic [1:0]              cs_s;
  logic [PW-1:0]           exact_s;
  logic                    s2_valid_r;
  logic [NA-1:0][W:0]      t_r;
  logic [NA-1:0][W-2:0]    b_r;
  logic [PW-1:0]           exact_r;
  logic [PW-1:0]           prod_s;
  logic                    cnt_inc_s;

  // The whole pipe moves together; it only stalls when a result is waiting unaccepted.
  assign adv_s    = out_ready | ~out_valid;
  assign in_ready = adv_s;

  // Stage 1: operand and mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      mode_r     <= '0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      x_r        <= in_x;
      y_r        <= in_y;
      mode_r     <= in_mode;
    end
  end

  // Compressed arrays: row 2k feeds A at column c, row 2k+1 feeds B from column c-1.
  always_comb begin
    t_s  = '0;
    b_s  = '0;
    cs_s = 2'b00;
    for (int k = 0; k < NA; k++) begin
      t_s[k][0] = x_r[2*k] & y_r[0];
      for (int c = 1; c < W; c++) begin
        cs_s = ha_cell(mode_r[2*(k*NC+c-1) +: 2], x_r[2*k] & y_r[c], x_r[2*k+1] & y_r[c-1]);
        t_s[k][c] = cs_s[0];
        if (c == W - 1) begin
          t_s[k][W] = cs_s[1];
        end else begin
          b_s[k][c-1] = cs_s[1];
        end
      end
      b_s[k][W-2] = x_r[2*k+1] & y_r[W-1];
    end
  end

  assign exact_s = PW'(x_r) * PW'(y_r);

  // Stage 2: array vectors and the exact reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      t_r        <= '0;
      b_r        <= '0;
      exact_r    <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      t_r        <= t_s;
      b_r        <= b_s;
      exact_r    <= exact_s;
    end
  end

  // Each array contributes t + 4*b, weighted by its row pair position.
  always_comb begin
    prod_s = '0;
    for (int k = 0; k < NA; k++) begin
      prod_s = prod_s + ((PW'(t_r[k]) + (PW'(b_r[k]) << 3'd2)) << (2 * k));
    end
  end

  // Stage 3: registered result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_prod     <= '0;
      out_exact    <= '0;
      out_mismatch <= 1'b0;
    end else if (adv_s) begin
      out_valid    <= s2_valid_r;
      out_prod     <= prod_s;
      out_exact    <= exact_r;
      out_mismatch <= (prod_s != exact_r);
    end
  end

  assign cnt_inc_s = out_valid & out_ready & out_mismatch & ~(&err_cnt);

  // Saturating mismatch counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (stats_clr) begin
      err_cnt <= '0;
    end else if (cnt_inc_s) begin
      err_cnt <= err_cnt + CNT_W'(1'b1);
    end
  end

endmodule

// File: tb/tb_approx_ha_array_mul_pipe.sv
// Scoreboard bench for approx_ha_array_mul_pipe: table vectors, random streams,
// latency, backpressure, mid-stream reset and counter saturation/clear.
module tb_approx_ha_array_mul_pipe;
  localparam int W  = 8;
  localparam int MW = (W/2)*(W-1)*2;
  localparam int PW = 2*W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready, out_mismatch, stats_clr;
  logic [W-1:0]  in_x, in_y;
  logic [MW-1:0] in_mode;
  logic [PW-1:0] out_prod, out_exact;
  logic [15:0]   err_cnt;
  logic          in_ready2, out_valid2, out_mismatch2;
  logic [PW-1:0] out_prod2, out_exact2;
  logic [1:0]    err_cnt2;

  approx_ha_array_mul_pipe #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_exact(out_exact),
    .out_mismatch(out_mismatch), .err_cnt(err_cnt), .stats_clr(stats_clr));

  approx_ha_array_mul_pipe #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_prod(out_prod2), .out_exact(out_exact2),
    .out_mismatch(out_mismatch2), .err_cnt(err_cnt2), .stats_clr(stats_clr));

  typedef struct {
    logic [PW-1:0] prod;
    logic [PW-1:0] exact;
    logic          mis;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [MW-1:0] mode;
    logic [PW-1:0] prod;
    logic [PW-1:0] exact;
    logic          mis;
  } vec_t;

  exp_t sb[$];
  vec_t tab[8];
  int n_tests = 0, n_fail = 0, cyc = 0, exp_err = 0, exp_err2 = 0;
  bit lat_chk = 1'b0, ovr = 1'b0, last_acc = 1'b0;
  logic [PW-1:0] ovr_prod, ovr_exact, hold_prod, hold_exact;
  logic ovr_mis, hold_mis;
  logic [MW-1:0] m00, m01, m10, m11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: compressor arrays rebuilt bit by bit from the column equations.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [MW-1:0] md);
    int sum, t, b, a, bb, s, cy;
    logic [1:0] m;
    sum = 0;
    for (int k = 0; k < W/2; k++) begin
      t = x[2*k] & y[0];
      b = 0;
      for (int c = 1; c < W; c++) begin
        a  = x[2*k] & y[c];
        bb = x[2*k+1] & y[c-1];
        m  = md[2*(k*(W-1)+c-1) +: 2];
        case (m)
          2'b00:   begin s = a ^ bb; cy = a & bb; end
          2'b01:   begin s = a | bb; cy = 0;      end
          2'b10:   begin s = 0;      cy = a;      end
          default: begin s = 0;      cy = 0;      end
        endcase
        t += s << c;
        if (c == W-1) t += cy << W;
        else          b += cy << (c-1);
      end
      b += (x[2*k+1] & y[W-1]) << (W-2);
      sum += (t + (b << 2)) << (2*k);
    end
    return PW'(sum);
  endfunction

  // One clock: sample just after the falling edge, update scoreboard, cross the rising edge.
  task automatic tick();
    logic acc, hs;
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    last_acc = acc;
    if (rst) begin
      sb.delete();
      exp_err = 0;
      exp_err2 = 0;
    end else begin
      if (hs) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got prod %0d, expected no output", out_prod);
        end else begin
          e = sb.pop_front();
          check("out_prod", out_prod, e.prod);
          check("out_exact", out_exact, e.exact);
          check("out_mismatch", out_mismatch, e.mis);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 3);
          if (e.mis && !stats_clr) begin
            if (exp_err < 65535) exp_err++;
            if (exp_err2 < 3) exp_err2++;
          end
        end
      end
      if (stats_clr) begin
        exp_err = 0;
        exp_err2 = 0;
      end
      if (acc) begin
        e.exact   = ovr ? ovr_exact : PW'(in_x) * PW'(in_y);
        e.prod    = ovr ? ovr_prod : model(in_x, in_y, in_mode);
        e.mis     = ovr ? ovr_mis : (e.prod != e.exact);
        e.acc_cyc = cyc;
        e.chk_lat = lat_chk;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
    check("drain_empty", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic check_cnt(input string name);
    check({name, "_err_cnt"}, err_cnt, exp_err);
    check({name, "_err_cnt2"}, err_cnt2, exp_err2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m00 = '0;
    m11 = '1;
    m01 = {(MW/2){2'b01}};
    m10 = {(MW/2){2'b10}};
    tab[0] = '{8'd255, 8'd255, m00, 16'd65025, 16'd65025, 1'b0};
    tab[1] = '{8'd255, 8'd255, m11, 16'd21845, 16'd65025, 1'b1};
    tab[2] = '{8'd255, 8'd255, m01, 16'd43435, 16'd65025, 1'b1};
    tab[3] = '{8'd255, 8'd255, m10, 16'd65025, 16'd65025, 1'b0};
    tab[4] = '{8'd1,   8'd1,   m11, 16'd1,     16'd1,     1'b0};
    tab[5] = '{8'd128, 8'd128, m11, 16'd16384, 16'd16384, 1'b0};
    tab[6] = '{8'd0,   8'd200, m01, 16'd0,     16'd0,     1'b0};
    tab[7] = '{8'd3,   8'd1,   m11, 16'd1,     16'd3,     1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    in_x = '0; in_y = '0; in_mode = '0;
    @(negedge clk);
    tick();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_prod", out_prod, 0);
    check("rst_out_exact", out_exact, 0);
    check("rst_out_mismatch", out_mismatch, 0);
    check("rst_err_cnt", err_cnt, 0);
    tick();
    rst = 1'b0;

    // Table vectors, one transaction at a time.
    for (int i = 0; i < 8; i++) begin
      in_x = tab[i].x; in_y = tab[i].y; in_mode = tab[i].mode;
      ovr = 1'b1; ovr_prod = tab[i].prod; ovr_exact = tab[i].exact; ovr_mis = tab[i].mis;
      in_valid = 1'b1;
      tick();
      ovr = 1'b0;
      drain();
      check_cnt("table");
    end
    check("table_err_cnt_total", err_cnt, 3);

    // Exact mode never mismatches.
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    in_mode = m00;
    for (int i = 0; i < 1000; i++) begin
      in_x = W'($urandom); in_y = W'($urandom); in_valid = 1'b1;
      tick();
    end
    drain();
    check("exact_mode_err_cnt", err_cnt, 0);

    // Random modes with random valid and backpressure.
    for (int i = 0, sent = 0; i < 3000 && sent < 300; i++) begin
      in_x = W'($urandom); in_y = W'($urandom); in_mode = MW'({$urandom, $urandom});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) sent++;
    end
    drain();
    check_cnt("random");

    // Back-to-back stream, modes alternating per transaction.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_x = W'($urandom_range(128, 255)); in_y = W'($urandom_range(128, 255));
      in_mode = (i % 2 == 1) ? m11 : m00;
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    lat_chk = 1'b0;
    drain();

    // Backpressure on a full pipeline.
    out_ready = 1'b0;
    in_mode = m11;
    for (int i = 0; i < 6; i++) begin
      in_x = W'($urandom); in_y = W'($urandom); in_valid = 1'b1;
      tick();
    end
    hold_prod = out_prod; hold_exact = out_exact; hold_mis = out_mismatch;
    for (int i = 0; i < 5; i++) begin
      in_x = W'($urandom); in_y = W'($urandom);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_prod_stable", out_prod, hold_prod);
      check("bp_exact_stable", out_exact, hold_exact);
      check("bp_mis_stable", out_mismatch, hold_mis);
      tick();
    end
    check("bp_inflight", sb.size(), 3);
    drain();
    check_cnt("bp");

    // Reset in the middle of a mismatching stream.
    in_x = 8'd255; in_y = 8'd255; in_mode = m11; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_err_cnt", err_cnt, exp_err);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_err_cnt", err_cnt, 0);
    check("post_rst_in_ready", in_ready, 1);
    drain();

    // Saturation of the narrow counter.
    in_x = 8'd255; in_y = 8'd255; in_mode = m11;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      tick();
    end
    drain();
    check("sat_err_cnt2", err_cnt2, 3);
    check("sat_err_cnt", err_cnt, 5);

    // Clear coincident with a mismatching handshake.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("clr_wait_out_valid", out_valid, 1);
    stats_clr = 1'b1;
    out_ready = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_err_cnt2", err_cnt2, 0);
    drain();
    check_cnt("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
